// File: rtl/uart_tx_flex.sv
// FIFO-fed UART transmitter: configurable data bits, stop bits and bit period, frames drain back-to-back.
// Define FLEX_UART_TX_PARITY_EN to add the per-frame even/odd parity bit selected by parity_mode.
module uart_tx_flex #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_data_valid,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic [1:0]                  parity_mode,
    output logic                        tx_data_ready,
    output logic                        tx_serial_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [NW-1:0] DATA_LAST  = NW'(DATA_BITS - 1);
    localparam logic [NW-1:0] STOP_LAST  = NW'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [LW-1:0]        level_reg;

    state_t               state_reg;
    logic [CW-1:0]        bit_cnt_reg;
    logic [NW-1:0]        idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_en_reg;
    logic                 par_bit_reg;

    logic                 push;
    logic                 pop;
    logic                 bit_last;
    logic                 line_next;
    logic [DATA_BITS-1:0] head_word;
    logic                 par_en_next;
    logic                 par_bit_next;

    assign tx_data_ready = (level_reg != FULL_LEVEL);
    assign fifo_level    = level_reg;
    assign push          = tx_data_valid && tx_data_ready;
    assign bit_last      = (bit_cnt_reg == BIT_LAST);
    assign head_word     = mem[rd_ptr_reg];

    // STOP hands the next word straight to START so consecutive frames abut.
    assign pop = (level_reg != '0) &&
                 ((state_reg == IDLE) ||
                  ((state_reg == STOP) && bit_last && (idx_reg == STOP_LAST)));

`ifdef FLEX_UART_TX_PARITY_EN
    assign par_en_next  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign par_bit_next = (^head_word) ^ (parity_mode == 2'b10);
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^parity_mode;
    assign par_en_next        = 1'b0;
    assign par_bit_next       = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_comb begin
        line_next = 1'b1;
        case (state_reg)
            START:   line_next = 1'b0;
            DATA:    line_next = shift_reg[0];
            PARITY:  line_next = par_bit_reg;
            default: line_next = 1'b1;
        endcase
    end

    // Line and busy are registered from the current state, so they trail it by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            par_en_reg    <= 1'b0;
            par_bit_reg   <= 1'b0;
            tx_serial_out <= 1'b1;
            tx_busy       <= 1'b0;
        end else begin
            tx_serial_out <= line_next;
            tx_busy       <= (state_reg != IDLE);
            if (state_reg != IDLE) begin
                bit_cnt_reg <= bit_last ? '0 : bit_cnt_reg + CW'(1);
            end
            if (pop) begin
                state_reg   <= START;
                bit_cnt_reg <= '0;
                idx_reg     <= '0;
                shift_reg   <= head_word;
                par_en_reg  <= par_en_next;
                par_bit_reg <= par_bit_next;
            end else if (bit_last) begin
                case (state_reg)
                    START: state_reg <= DATA;
                    DATA: begin
                        shift_reg <= shift_reg >> 1;
                        if (idx_reg == DATA_LAST) begin
                            idx_reg   <= '0;
                            state_reg <= par_en_reg ? PARITY : STOP;
                        end else begin
                            idx_reg <= idx_reg + NW'(1);
                        end
                    end
                    PARITY: state_reg <= STOP;
                    STOP: begin
                        if (idx_reg == STOP_LAST) begin
                            state_reg <= IDLE;
                        end else begin
                            idx_reg <= idx_reg + NW'(1);
                        end
                    end
                    default: state_reg <= state_reg;
                endcase
            end
        end
    end

endmodule
